// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 bit mux one channel at a time and packs the sampled bits into a word with a valid/ready output.
// Optional free-running mode: define MUX_SCAN_AUTO_EN to start scans automatically and ignore the start port.
module mux_scan_sampler #(
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  input  logic             f_in,
  output logic             busy,
  output logic [N_CH-1:0]  data,
  output logic             valid,
  input  logic             ready
);

  localparam int CNT_W = $clog2(SETTLE) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_shadow;

  logic             w_start;
  logic             w_sample;
  logic [N_CH-1:0]  w_word;

`ifdef MUX_SCAN_AUTO_EN
  assign w_start = 1'b1;
`else
  assign w_start = start;
`endif

  // The sample edge is the last cycle of the settle window for the current channel.
  assign w_sample = (r_state == S_SETTLE) && (r_cnt == CNT_LAST);

  // NOTE: the shadow copy is assigned first so the single-bit overwrite below never leaves w_word unassigned (no latch).
  always_comb begin
    w_word      = r_shadow;
    w_word[sel] = f_in;
  end

  // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          sel <= '0;
          if (w_start) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (w_sample) begin
            r_shadow <= w_word;
            r_cnt    <= '0;
            if (sel == SEL_LAST) begin
              r_state <= S_OUT;
              data    <= w_word;
              valid   <= 1'b1;
              sel     <= '0;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_OUT: begin
          // Start is honoured here only together with the handshake; otherwise it is dropped.
          if (ready) begin
            valid <= 1'b0;
            if (w_start) begin
              r_state <= S_SETTLE;
              r_cnt   <= '0;
              sel     <= '0;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          sel     <= '0;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler (default build): a bench-side 4:1 mux feeds f_in, a scoreboard checks every delivered word.
module tb_mux_scan_sampler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] sel;
  logic       f_in;
  logic       busy;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic [3:0] a_bank;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  mux_scan_sampler #(.N_CH(4), .SEL_W(2), .SETTLE(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sel  (sel),
    .f_in (f_in),
    .busy (busy),
    .data (data),
    .valid(valid),
    .ready(ready)
  );

  assign f_in = a_bank[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard consumer: each valid&ready handshake must deliver the oldest expected word.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_data", data, exp_q.pop_front());
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    ready  = 1'b1;
    a_bank = 4'b0000;
    #12;
    check("rst_sel",   sel,   0);
    check("rst_busy",  busy,  0);
    check("rst_valid", valid, 0);
    check("rst_data",  data,  0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // 1: basic scan, sel sequence and latency, ready already high.
    a_bank = 4'b0101;
    start  = 1'b1;
    exp_q.push_back(4'b0101);
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_sel%0d", k), sel, k / 2);
      check($sformatf("t1_nv%0d", k), valid, 0);
      tick();
    end
    check("t1_valid_e8", valid, 1);
    check("t1_sel_out", sel, 0);
    tick();
    check("t1_valid_drop", valid, 0);
    check("t1_busy_after", busy, 0);
    check("t1_data_kept", data, 4'b0101);

    // 2: backpressure holds word; input changes during the wait do not leak through.
    ready  = 1'b0;
    a_bank = 4'b1010;
    start  = 1'b1;
    exp_q.push_back(4'b1010);
    tick();
    start = 1'b0;
    wait_valid(n);
    check("t2_latency", n, 8);
    a_bank = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_valid", valid, 1);
      check("t2_hold_data", data, 4'b1010);
      check("t2_busy_out", busy, 1);
      tick();
    end
    ready = 1'b1;
    tick();
    check("t2_valid_drop", valid, 0);
    check("t2_idle", busy, 0);

    // 3: reset mid-scan aborts at once, then a fresh scan works.
    a_bank = 4'b0110;
    start  = 1'b1;
    exp_q.push_back(4'b0110);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t3_pre_busy", busy, 1);
    check("t3_pre_sel", sel, 1);
    rst = 1'b1;
    #1;
    check("t3_sel", sel, 0);
    check("t3_busy", busy, 0);
    check("t3_valid", valid, 0);
    check("t3_data", data, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("t3_no_valid", valid, 0);
    a_bank = 4'b0011;
    start  = 1'b1;
    exp_q.push_back(4'b0011);
    tick();
    start = 1'b0;
    wait_valid(n);
    check("t3_latency", n, 8);
    tick();
    check("t3_idle", busy, 0);

    // 4: start held high; no mid-scan restart, back-to-back scan from OUT.
    a_bank = 4'b1100;
    start  = 1'b1;
    exp_q.push_back(4'b1100);
    tick();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_sel%0d", k), sel, k / 2);
      tick();
    end
    check("t4_valid1", valid, 1);
    a_bank = 4'b1001;
    exp_q.push_back(4'b1001);
    tick();
    check("t4_restart_busy", busy, 1);
    check("t4_restart_valid", valid, 0);
    check("t4_restart_sel", sel, 0);
    start = 1'b0;
    wait_valid(n);
    check("t4_latency2", n, 8);
    tick();
    check("t4_idle", busy, 0);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
